// File: rtl/bmw_trace_pkg.sv
// Shared types and entry-layout helpers for the trace feeder and the trace reader stage.
package bmw_trace_pkg;

  typedef enum logic [1:0] {IDLE, FILL, PLAY, DONE} trace_state_e;

  // Entry width: the wider of the idle and push layouts, plus the push/idle flag MSB.
  function automatic int trace_data_bits(int idlecycle, int ptw, int tree_num_bits, int mtw);
    int push_w;
    push_w = ptw + tree_num_bits + mtw + ptw;
    return ((idlecycle > push_w) ? idlecycle : push_w) + 1;
  endfunction

  // Push entry layout for the default configuration: {prio, tree_id, data}, data = {meta, payload}.
  localparam int DEF_PTW           = 16;
  localparam int DEF_MTW           = 2;
  localparam int DEF_TREE_NUM_BITS = 2;
  localparam int PUSH_DATA_LSB     = 0;
  localparam int PUSH_TREE_LSB     = DEF_PTW + DEF_MTW;
  localparam int PUSH_PRIO_LSB     = PUSH_TREE_LSB + DEF_TREE_NUM_BITS;
  localparam int IDLE_CYCLES_LSB   = 0;

endpackage

// File: rtl/trace_sram.sv
// 1R1W trace memory: synchronous read with registered output, read-before-write, no reset.
module trace_sram #(
  parameter int DEPTH     = 1024,
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_feeder.sv
// Trace replay sequencer: SRAM behind a 2-entry prefetch FIFO, one entry per cycle on i_read.
// Optional build macro TRACE_LOOP_EN: replay loops continuously and i_start restarts while busy.
module trace_feeder
  import bmw_trace_pkg::*;
#(
  parameter int PTW         = 16,
  parameter int MTW         = 2,
  parameter int TREE_NUM    = 4,
  parameter int IDLECYCLE   = 1024,
  parameter int TRACE_DEPTH = 1024,
  localparam int TREE_NUM_BITS   = $clog2(TREE_NUM),
  localparam int ADDR_BITS       = $clog2(TRACE_DEPTH),
  localparam int LEN_BITS        = $clog2(TRACE_DEPTH + 1),
  localparam int TRACE_DATA_BITS = trace_data_bits(IDLECYCLE, PTW, TREE_NUM_BITS, MTW)
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic                       i_wr_en,
  input  logic [ADDR_BITS-1:0]       i_wr_addr,
  input  logic [TRACE_DATA_BITS-1:0] i_wr_data,
  input  logic                       i_start,
  input  logic [LEN_BITS-1:0]        i_len,
  input  logic                       i_read,
  output logic [TRACE_DATA_BITS-1:0] o_trace_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [LEN_BITS-1:0]        o_consumed,
  output logic                       o_underflow
);

  trace_state_e               state_q, state_d;
  logic [LEN_BITS-1:0]        len_q, fetch_ptr_q, consumed_q;
  logic                       inflight_q, rd_ptr_q, wr_ptr_q, underflow_q, done_pulse_q;
  logic [1:0]                 occ_q, credit, fill_target;
  logic [TRACE_DATA_BITS-1:0] fifo_q [2];
  logic [TRACE_DATA_BITS-1:0] sram_rd_data;
  logic                       start_ok, pop, underrun, last_pop, fetch, idle_or_done, active;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign active       = (state_q == FILL) || (state_q == PLAY);
`ifdef TRACE_LOOP_EN
  assign start_ok = i_start;
`else
  assign start_ok = i_start && idle_or_done;
`endif
  assign pop      = (state_q == PLAY) && i_read && (occ_q != 2'd0);
  assign underrun = (state_q == PLAY) && i_read && (occ_q == 2'd0);
  assign last_pop = pop && (consumed_q == len_q - LEN_BITS'(1));
  // A pop this cycle frees a slot, which is what keeps one entry per cycle flowing.
  assign credit   = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign fetch    = active && !start_ok && (credit < 2'd2) && (fetch_ptr_q < len_q);
  assign fill_target = (len_q > LEN_BITS'(1)) ? 2'd2 : len_q[1:0];

  trace_sram #(
    .DEPTH     (TRACE_DEPTH),
    .WIDTH     (TRACE_DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_sram (
    .i_clk   (i_clk),
    .wr_en   (i_wr_en && idle_or_done),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (fetch),
    .rd_addr (fetch_ptr_q[ADDR_BITS-1:0]),
    .rd_data (sram_rd_data)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_ok) begin
      state_d = (i_len == '0) ? DONE : FILL;
    end else begin
      case (state_q)
        FILL:    if (occ_q >= fill_target) state_d = PLAY;
`ifndef TRACE_LOOP_EN
        PLAY:    if (last_pop) state_d = DONE;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_busy       = active;
    o_done       = (state_q == DONE) || done_pulse_q;
    o_trace_data = pop ? fifo_q[rd_ptr_q] : '0;
  end

  // Stage p0 -> p1: fetch issue, FIFO bookkeeping, consume counter.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      len_q        <= '0;
      fetch_ptr_q  <= '0;
      consumed_q   <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      underflow_q  <= 1'b0;
      done_pulse_q <= 1'b0;
    end else if (start_ok) begin
      len_q        <= i_len;
      fetch_ptr_q  <= '0;
      consumed_q   <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      underflow_q  <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      inflight_q <= fetch;
      if (fetch) begin
`ifdef TRACE_LOOP_EN
        fetch_ptr_q <= (fetch_ptr_q == len_q - LEN_BITS'(1)) ? '0 : fetch_ptr_q + LEN_BITS'(1);
`else
        fetch_ptr_q <= fetch_ptr_q + LEN_BITS'(1);
`endif
      end
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
`ifdef TRACE_LOOP_EN
        consumed_q <= last_pop ? '0 : consumed_q + LEN_BITS'(1);
`else
        consumed_q <= consumed_q + LEN_BITS'(1);
`endif
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (underrun) underflow_q <= 1'b1;
`ifdef TRACE_LOOP_EN
      done_pulse_q <= last_pop;
`else
      done_pulse_q <= 1'b0;
`endif
    end
  end

  // Stage p1 -> FIFO: SRAM read data lands one cycle after issue.
  always_ff @(posedge i_clk) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= sram_rd_data;
  end

  assign o_consumed  = consumed_q;
  assign o_underflow = underflow_q;

endmodule

// File: tb/tb_trace_feeder.sv
// Directed/randomized bench for trace_feeder; reference is an array of loaded entries replayed in order.
module tb_trace_feeder;
  import bmw_trace_pkg::*;

  localparam int PTW = 16, MTW = 2, TREE_NUM = 4, IDLECYCLE = 1024, TRACE_DEPTH = 1024;
  localparam int ADDR_BITS = $clog2(TRACE_DEPTH);
  localparam int LEN_BITS  = $clog2(TRACE_DEPTH + 1);
  localparam int TDB       = trace_data_bits(IDLECYCLE, PTW, $clog2(TREE_NUM), MTW);

  logic                 i_clk = 1'b0;
  logic                 i_arst_n = 1'b0;
  logic                 i_wr_en = 1'b0;
  logic [ADDR_BITS-1:0] i_wr_addr = '0;
  logic [TDB-1:0]       i_wr_data = '0;
  logic                 i_start = 1'b0;
  logic [LEN_BITS-1:0]  i_len = '0;
  logic                 i_read = 1'b0;
  logic [TDB-1:0]       o_trace_data;
  logic                 o_busy, o_done, o_underflow;
  logic [LEN_BITS-1:0]  o_consumed;

  int checks = 0;
  int errors = 0;
  logic [TDB-1:0] mem_model [16];

  always #5 i_clk = ~i_clk;

  trace_feeder #(
    .PTW(PTW), .MTW(MTW), .TREE_NUM(TREE_NUM), .IDLECYCLE(IDLECYCLE), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .i_len(i_len), .i_read(i_read),
    .o_trace_data(o_trace_data), .o_busy(o_busy), .o_done(o_done),
    .o_consumed(o_consumed), .o_underflow(o_underflow)
  );

  task automatic chk(input string tag, input logic [TDB-1:0] obs, input logic [TDB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [TDB-1:0] make_push();
    logic [TDB-1:0] e;
    e = '0;
    e[TDB-1] = 1'b1;
    e[PUSH_PRIO_LSB +: 16] = 16'($urandom);
    e[PUSH_TREE_LSB +: 2]  = 2'($urandom);
    e[PUSH_DATA_LSB +: 18] = 18'($urandom);
    return e;
  endfunction

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      mem_model[i] = make_push();
      @(posedge i_clk); #1;
      i_wr_en = 1'b1; i_wr_addr = ADDR_BITS'(i); i_wr_data = mem_model[i];
    end
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic start(input int len);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_len = LEN_BITS'(len);
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // mode 0: read every cycle; 1: 20 idle cycles then read; 2: read on alternate cycles
  task automatic collect(input int len, input int n, input int mode, input string tag,
                         output int first_cyc, output int last_cyc, output int dones);
    int idx = 0;
    int cyc = 0;
    first_cyc = 0; last_cyc = 0; dones = 0;
    while (idx < n && cyc < 400) begin
      case (mode)
        0:       i_read = 1'b1;
        1:       i_read = (cyc >= 20);
        default: i_read = (cyc % 2 == 0);
      endcase
      @(negedge i_clk);
      if (o_done) dones++;
      if (!i_read) begin
        chk({tag, "_noread_zero"}, o_trace_data, '0);
      end else if (o_trace_data !== '0) begin
        chk($sformatf("%s_entry%0d", tag, idx), o_trace_data, mem_model[idx % len]);
        if (idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    checks++;
    assert (idx == n) else begin
      errors++;
      $error("FAIL %s_timeout got=%0d want=%0d", tag, idx, n);
    end
  endtask

  initial begin
    int f, l, d;
    #12;
    @(negedge i_clk);
    chk("rst_busy", TDB'(o_busy), '0);
    chk("rst_done", TDB'(o_done), '0);
    chk("rst_consumed", TDB'(o_consumed), '0);
    chk("rst_underflow", TDB'(o_underflow), '0);
    chk("rst_data", o_trace_data, '0);
    @(posedge i_clk); #1;
    i_arst_n = 1'b1;

`ifndef TRACE_LOOP_EN
    load(6);
    start(4);
    collect(4, 4, 0, "t1", f, l, d);
    chk("t1_consecutive", TDB'(l - f), TDB'(3));
    @(negedge i_clk);
    chk("t1_done", TDB'(o_done), TDB'(1));
    chk("t1_consumed", TDB'(o_consumed), TDB'(4));
    chk("t1_data_after", o_trace_data, '0);
    chk("t1_busy", TDB'(o_busy), '0);

    start(4);
    collect(4, 4, 1, "t2", f, l, d);
    chk("t2_consecutive", TDB'(l - f), TDB'(3));
    @(negedge i_clk);
    chk("t2_consumed", TDB'(o_consumed), TDB'(4));

    start(6);
    collect(6, 6, 2, "t3", f, l, d);
    @(negedge i_clk);
    chk("t3_underflow", TDB'(o_underflow), '0);
    chk("t3_consumed", TDB'(o_consumed), TDB'(6));

    start(0);
    i_read = 1'b1;
    @(negedge i_clk);
    chk("t4_done", TDB'(o_done), TDB'(1));
    chk("t4_busy", TDB'(o_busy), '0);
    chk("t4_consumed", TDB'(o_consumed), '0);
    chk("t4_data", o_trace_data, '0);

    start(5);
    collect(5, 2, 0, "t5a", f, l, d);
    i_read = 1'b0;
    i_arst_n = 1'b0;
    #1;
    chk("t5_rst_busy", TDB'(o_busy), '0);
    chk("t5_rst_done", TDB'(o_done), '0);
    chk("t5_rst_consumed", TDB'(o_consumed), '0);
    chk("t5_rst_data", o_trace_data, '0);
    @(posedge i_clk); #1;
    i_arst_n = 1'b1;
    start(5);
    collect(5, 5, 0, "t5b", f, l, d);
    @(negedge i_clk);
    chk("t5_done", TDB'(o_done), TDB'(1));
    chk("t5_consumed", TDB'(o_consumed), TDB'(5));
`else
    load(3);
    start(3);
    collect(3, 6, 0, "t6", f, l, d);
    chk("t6_consecutive", TDB'(l - f), TDB'(5));
    @(negedge i_clk);
    if (o_done) d++;
    chk("t6_done_pulses", TDB'(d), TDB'(2));
    chk("t6_busy", TDB'(o_busy), TDB'(1));
    chk("t6_underflow", TDB'(o_underflow), '0);
    start(0);
    @(negedge i_clk);
    chk("t6_restart_len0_done", TDB'(o_done), TDB'(1));
    chk("t6_restart_len0_busy", TDB'(o_busy), '0);
    chk("t6_restart_len0_consumed", TDB'(o_consumed), '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
